pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 8 +
 rtl/pipeline_controller_mem_wait_timer.sv | 15 +
 rtl/pipeline_controller.sv | 92 +++++++++
 tb/tb_pipeline_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared control types and hazard helper for the pipeline controller
package pipeline_controller_pkg;
  localparam int REG_IDX_W = 5;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, STEP} pipe_ctrl_state_t;
  function automatic logic load_use_hit(input logic rd, input logic [REG_IDX_W-1:0] wr, r1, r2);
    return rd && wr != '0 && (wr == r1 || wr == r2);
  endfunction
endpackage

// File: rtl/pipeline_controller_mem_wait_timer.sv
// mem_wait_timer: counts consecutive freeze cycles; expired flags the MEM_WAIT_MAX-th one
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(MEM_WAIT_MAX + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk) count <= (rst || clear) ? '0 : count_en ? count + 1'b1 : count;
  assign expired = count_en && count == W'(MEM_WAIT_MAX - 1);
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush/halt control for a 5-stage pipeline
// PIPE_CTRL_PERF_EN adds stall_count and flush_count performance counters.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_do_read_ctrl_ex,
  input  logic [REG_IDX_W-1:0] wr_reg_idx_ex,
  input  logic [REG_IDX_W-1:0] r1_reg_idx_id,
  input  logic [REG_IDX_W-1:0] r2_reg_idx_id,
  input  logic                 branch_taken_ex,
  input  logic                 dmem_req_mem,
  input  logic                 dmem_ready,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 resume_req,
  output logic                 pc_enable,
  output logic                 if_id_enable,
  output logic                 if_id_clear,
  output logic                 id_ex_enable,
  output logic                 id_ex_clear,
  output logic                 ex_mem_enable,
  output logic                 ex_mem_clear,
  output logic                 mem_wb_enable,
  output logic                 mem_wb_clear,
  output logic                 halted,
  output logic                 mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_count,
  output logic [31:0]          flush_count
`endif
);
  pipe_ctrl_state_t state;
  logic active, freeze, go, flush, hazard, stall, expired, halt_after, lu_q;
  assign active = !rst && state != HALTED;
  assign freeze = active && dmem_req_mem && !dmem_ready;
  assign go = active && !freeze;
  assign flush = go && branch_taken_ex;
  // lu_q masks the hazard for the cycle after a bubble so a stall never exceeds one cycle
  assign hazard = load_use_hit(mem_do_read_ctrl_ex, wr_reg_idx_ex, r1_reg_idx_id, r2_reg_idx_id) && !lu_q;
  assign stall = go && !branch_taken_ex && hazard;
  assign pc_enable = go && !stall;
  assign if_id_enable = go && !stall;
  assign if_id_clear = rst || flush;
  assign id_ex_enable = go;
  assign id_ex_clear = rst || flush || stall;
  assign ex_mem_enable = go;
  assign ex_mem_clear = rst;
  assign mem_wb_enable = go;
  assign mem_wb_clear = rst;
  assign halted = !rst && state == HALTED;
  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
    .clk(clk),
    .rst(rst),
    .count_en(freeze),
    .clear(!freeze),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      halt_after <= 1'b0;
      lu_q <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      lu_q <= freeze ? lu_q : stall;
      if (expired) mem_timeout <= 1'b1;
      if (freeze) begin
        state <= expired ? HALTED : MEM_WAIT;
        halt_after <= (state == MEM_WAIT && halt_after) || state == STEP || halt_req;
      end else begin
        halt_after <= 1'b0;
        unique case (state)
          RUN:      state <= halt_req ? HALTED : RUN;
          MEM_WAIT: state <= (halt_after || halt_req) ? HALTED : RUN;
          STEP:     state <= HALTED;
          HALTED:   state <= resume_req ? RUN : step_req ? STEP : HALTED;
        endcase
      end
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    stall_count <= rst ? '0 : stall_count + 32'(freeze || stall);
    flush_count <= rst ? '0 : flush_count + 32'(flush);
  end
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed self-checking bench for pipeline_controller
module tb_pipeline_controller;
  logic clk = 1'b0;
  logic rst, mem_do_read_ctrl_ex, branch_taken_ex, dmem_req_mem, dmem_ready;
  logic halt_req, step_req, resume_req;
  logic [4:0] wr_reg_idx_ex, r1_reg_idx_id, r2_reg_idx_id;
  logic pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear;
  logic ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear, halted, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif
  int total = 0, bad = 0;
  // {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr}
  localparam logic [8:0] ALL_EN = 9'b110101010;
  localparam logic [8:0] RST_C  = 9'b001010101;
  localparam logic [8:0] LU_C   = 9'b000011010;
  localparam logic [8:0] LU_M   = 9'b111011111;
  localparam logic [8:0] FL_C   = 9'b101011010;
  localparam logic [8:0] FL_M   = 9'b101011111;
  always #5 clk = ~clk;
  pipeline_controller dut (
    .clk(clk), .rst(rst),
    .mem_do_read_ctrl_ex(mem_do_read_ctrl_ex), .wr_reg_idx_ex(wr_reg_idx_ex),
    .r1_reg_idx_id(r1_reg_idx_id), .r2_reg_idx_id(r2_reg_idx_id),
    .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_clear(if_id_clear),
    .id_ex_enable(id_ex_enable), .id_ex_clear(id_ex_clear),
    .ex_mem_enable(ex_mem_enable), .ex_mem_clear(ex_mem_clear),
    .mem_wb_enable(mem_wb_enable), .mem_wb_clear(mem_wb_clear),
    .halted(halted), .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );
  function automatic logic [8:0] ctl();
    return {pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear,
            ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    mem_do_read_ctrl_ex = 0; wr_reg_idx_ex = 0; r1_reg_idx_id = 0; r2_reg_idx_id = 0;
    branch_taken_ex = 0; dmem_req_mem = 0; dmem_ready = 0;
    halt_req = 0; step_req = 0; resume_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    rst = 1; idle();
    tick(); tick();
    #3 chk("rst_ctl", ctl(), RST_C); chk("rst_halted", halted, 0); chk("rst_to", mem_timeout, 0);
    tick(); rst = 0;
    #3 chk("run", ctl(), ALL_EN);
    tick(); mem_do_read_ctrl_ex = 1; wr_reg_idx_ex = 5; r1_reg_idx_id = 5;
    #3 chk("lu_r1", ctl() & LU_M, LU_C);
    tick();
    #3 chk("lu_once", ctl(), ALL_EN);
    tick(); idle(); mem_do_read_ctrl_ex = 1; wr_reg_idx_ex = 7; r2_reg_idx_id = 7;
    #3 chk("lu_r2", ctl() & LU_M, LU_C);
    tick(); idle(); mem_do_read_ctrl_ex = 1;
    #3 chk("lu_x0", ctl(), ALL_EN);
    tick(); idle(); mem_do_read_ctrl_ex = 1; wr_reg_idx_ex = 3; r1_reg_idx_id = 3; branch_taken_ex = 1;
    #3 chk("flush_lu", ctl() & FL_M, FL_C);
    tick(); idle(); dmem_req_mem = 1;
    for (int i = 0; i < 3; i++) begin
      #3 chk("frz", ctl(), 0); chk("frz_halted", halted, 0);
      tick();
    end
    dmem_ready = 1;
    #3 chk("release", ctl(), ALL_EN);
    tick(); idle();
    #3 chk("rel_run", ctl(), ALL_EN); chk("rel_halted", halted, 0);
    tick(); halt_req = 1;
    #3 chk("halt_cyc", ctl(), ALL_EN);
    tick(); halt_req = 0;
    #3 chk("halted", halted, 1); chk("halted_ctl", ctl(), 0);
    tick(); step_req = 1;
    #3 chk("step_req_halted", halted, 1);
    tick(); step_req = 0;
    #3 chk("step_ctl", ctl(), ALL_EN); chk("step_halted", halted, 0);
    tick();
    #3 chk("step_back", halted, 1); chk("step_back_ctl", ctl(), 0);
    tick(); resume_req = 1;
    tick(); resume_req = 0;
    #3 chk("resume", halted, 0); chk("resume_ctl", ctl(), ALL_EN);
    tick(); halt_req = 1;
    tick(); halt_req = 0; step_req = 1; resume_req = 1;
    tick(); step_req = 0; resume_req = 0;
    tick();
    #3 chk("resume_wins", halted, 0);
    tick(); dmem_req_mem = 1;
    for (int i = 0; i < 15; i++) begin
      #3 chk("to_frz", ctl(), 0);
      if (i == 14) chk("to_pre", mem_timeout, 0);
      tick();
    end
    #3 chk("to_flag", mem_timeout, 1); chk("to_halted", halted, 1);
    tick(); idle(); resume_req = 1;
    tick(); resume_req = 0;
    #3 chk("to_sticky", mem_timeout, 1); chk("to_resume", halted, 0);
    tick(); rst = 1;
    tick(); rst = 0;
    #3 chk("to_cleared", mem_timeout, 0);
    tick(); branch_taken_ex = 1;
    #3 chk("fl1", ctl() & FL_M, FL_C);
    tick();
    #3 chk("fl2", ctl() & FL_M, FL_C);
    tick(); idle();
`ifdef PIPE_CTRL_PERF_EN
    #3 chk("flush_cnt", flush_count, 2);
`endif
    dmem_req_mem = 1;
    tick(); tick(); rst = 1;
    #3 chk("rst_mw_ctl", ctl(), RST_C); chk("rst_mw_halted", halted, 0);
    tick(); rst = 0;
`ifdef PIPE_CTRL_PERF_EN
    #3 chk("flush_cnt_rst", flush_count, 0); chk("stall_cnt_rst", stall_count, 0);
`endif
    for (int i = 0; i < 14; i++) tick();
    dmem_ready = 1;
    #3 chk("cnt_cleared", ctl(), ALL_EN); chk("cnt_to", mem_timeout, 0);
    tick(); idle();
    #3 chk("end_run", halted, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
